// File: rtl/subtractor_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM states,
// and the bit-counter sizing rule.
package subtractor_serial_pkg;

  localparam int WIDTH_DEF = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The counter must hold WIDTH+1 after the last increment.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/subtractor_serial_full_subtractor.sv
// Single-bit full subtractor cell; the counterpart of the full adder, reusable
// for a ripple subtractor.
module full_subtractor (
  output logic bout,
  output logic diff,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial borrow-ripple subtractor: out = in0 - in1, one bit per clock,
// LSB first, with a start/done handshake.
module subtractor_serial
  import subtractor_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [WIDTH:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic           busy,
  output logic           done,
  output logic [WIDTH:0] out,
  output logic           borrow
);

  localparam int CW = cnt_w(WIDTH);

  state_t         state_q, state_d;
  logic [WIDTH:0] a_q, a_d, b_q, b_d, r_q, r_d, out_q, out_d;
  logic           bin_q, bin_d, borrow_q, borrow_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           d, bout;

  full_subtractor u_fs (
    .bout (bout),
    .diff (d),
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = in0;
          b_d     = {1'b0, in1};
          bin_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        r_d   = {d, r_q[WIDTH:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bin_d = bout;
        cnt_d = cnt_q + 1'b1;
        // Results are published only once the top bit is in, so callers
        // never observe a partially shifted difference.
        if (cnt_q == CW'(WIDTH)) begin
          state_d  = S_DONE;
          out_d    = {d, r_q[WIDTH:1]};
          borrow_d = bout;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign out    = out_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Scoreboarded bench for subtractor_serial: expected differences are queued at
// request time and checked when done pulses.
module tb_subtractor_serial;

  localparam int W = 9;

  typedef struct packed {
    logic [W:0] out;
    logic       borrow;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W:0]   in0;
  logic [W-1:0] in1;
  logic         busy, done, borrow;
  logic [W:0]   out;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_cnt = 0;

  subtractor_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in0    (in0),
    .in1    (in1),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    logic [W+1:0] diff;
    diff     = (W+2)'(a - b);
    e.out    = diff[W:0];
    e.borrow = (a < b);
    return e;
  endfunction

  task automatic issue(input int a, input int b);
    @(negedge clk);
    start = 1'b1;
    in0   = (W+1)'(a);
    in1   = W'(b);
    sb.push_back(model(a, b));
  endtask

  // Cycles are counted at negedges starting with the one after the accept edge.
  task automatic wait_done(output int n, output int busy_n, output bit ok);
    n = 0; busy_n = 0; ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) busy_n++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in0 = '0; in1 = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (out !== '0) begin tests_failed++; $display("FAIL reset_out got %0d exp 0", out); end
    tests_run++; if (borrow !== 1'b0) begin tests_failed++; $display("FAIL reset_borrow got %b exp 0", borrow); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int n, bn; bit ok; exp_t e;
    issue(300, 45);
    wait_done(n, bn, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_timeout no done in %0d cycles", n); end
    else begin
      e = sb.pop_front();
      tests_run++; if (n - 1 !== 10) begin tests_failed++; $display("FAIL basic_latency got %0d exp 10", n - 1); end
      tests_run++; if (bn !== 11) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d exp 11", bn); end
      tests_run++; if (out !== e.out) begin tests_failed++; $display("FAIL basic_out got %0d exp %0d", out, e.out); end
      tests_run++; if (borrow !== e.borrow) begin tests_failed++; $display("FAIL basic_borrow got %b exp %b", borrow, e.borrow); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_width got %b exp 0", done); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_drop got %b exp 0", busy); end
    end
  endtask

  task automatic test_arith();
    int n, bn; bit ok; exp_t e;
    int a_tab[3] = '{0, 1022, 511};
    int b_tab[3] = '{1, 511, 511};
    for (int k = 0; k < 3; k++) begin
      issue(a_tab[k], b_tab[k]);
      wait_done(n, bn, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL arith%0d_timeout no done", k); end
      else begin
        e = sb.pop_front();
        tests_run++; if (out !== e.out) begin tests_failed++; $display("FAIL arith%0d_out got %0d exp %0d", k, out, e.out); end
        tests_run++; if (borrow !== e.borrow) begin tests_failed++; $display("FAIL arith%0d_borrow got %b exp %b", k, borrow, e.borrow); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    int d0, done_at; exp_t e;
    d0 = done_cnt; done_at = -1;
    issue(600, 100);
    for (int cyc = 0; cyc < 26; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (cyc == 2 || cyc == 10) begin start = 1'b1; in0 = 10'd5; in1 = 9'd9; end
      if (done) begin
        done_at = cyc;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          tests_run++; if (out !== e.out) begin tests_failed++; $display("FAIL ignored_out got %0d exp %0d", out, e.out); end
          tests_run++; if (borrow !== e.borrow) begin tests_failed++; $display("FAIL ignored_borrow got %b exp %b", borrow, e.borrow); end
        end
      end
    end
    tests_run++; if (done_at !== 10) begin tests_failed++; $display("FAIL ignored_done_cycle got %0d exp 10", done_at); end
    tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL ignored_done_count got %0d exp 1", done_cnt - d0); end
    tests_run++; if (out !== 10'd500) begin tests_failed++; $display("FAIL ignored_out_hold got %0d exp 500", out); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ignored_busy got %b exp 0", busy); end
  endtask

  task automatic test_mid_reset();
    int n, bn, d0; bit ok; exp_t e;
    issue(50, 20);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    tests_run++; if (out !== '0) begin tests_failed++; $display("FAIL midrst_out got %0d exp 0", out); end
    tests_run++; if (borrow !== 1'b0) begin tests_failed++; $display("FAIL midrst_borrow got %b exp 0", borrow); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b exp 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done got %b exp 0", done); end
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    tests_run++; if (done_cnt !== d0) begin tests_failed++; $display("FAIL midrst_no_done got %0d exp 0", done_cnt - d0); end
    issue(100, 1);
    wait_done(n, bn, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL midrst_timeout no done after restart"); end
    else begin
      e = sb.pop_front();
      tests_run++; if (n - 1 !== 10) begin tests_failed++; $display("FAIL midrst_latency got %0d exp 10", n - 1); end
      tests_run++; if (out !== e.out) begin tests_failed++; $display("FAIL midrst_out2 got %0d exp %0d", out, e.out); end
      tests_run++; if (borrow !== e.borrow) begin tests_failed++; $display("FAIL midrst_borrow2 got %b exp %b", borrow, e.borrow); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int at[$]; exp_t e;
    @(negedge clk);
    start = 1'b1; in0 = 10'd7; in1 = 9'd3;
    repeat (3) sb.push_back(model(7, 3));
    for (int cyc = 0; cyc < 36; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 35) start = 1'b0;
      if (done) begin
        at.push_back(cyc);
        tests_run++;
        if (sb.size() == 0) begin tests_failed++; $display("FAIL held_extra_done at cycle %0d", cyc); end
        else begin
          e = sb.pop_front();
          if (out !== e.out || borrow !== e.borrow) begin
            tests_failed++;
            $display("FAIL held_result got %0d/%b exp %0d/%b", out, borrow, e.out, e.borrow);
          end
        end
      end
    end
    tests_run++; if (at.size() !== 3) begin tests_failed++; $display("FAIL held_done_count got %0d exp 3", at.size()); end
    else begin
      tests_run++; if (at[1] - at[0] !== 12) begin tests_failed++; $display("FAIL held_gap0 got %0d exp 12", at[1] - at[0]); end
      tests_run++; if (at[2] - at[1] !== 12) begin tests_failed++; $display("FAIL held_gap1 got %0d exp 12", at[2] - at[1]); end
    end
    repeat (13) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL held_final_busy got %b exp 0", busy); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/subtractor_serial.md
# subtractor_serial

Bit-serial borrow-ripple subtractor. It computes `in0 - in1` one bit per clock, where `in0` is a 10-bit minuend (the width of a 9+9-bit sum) and `in1` is a 9-bit subtrahend. It is the inverse datapath to the ripple adder and is used where sums must be taken apart again: score or coordinate deltas, and undoing an accumulated offset. It trades latency for area with a single full-subtractor cell and a small FSM with a start/done handshake.

## Interface
- `WIDTH`, default 9: subtrahend width. Minuend, result and internal registers are `WIDTH+1` bits.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only in IDLE.
- `in0` input `WIDTH+1`: minuend. Latched when `start` is accepted.
- `in1` input `WIDTH`: subtrahend. Latched when `start` is accepted and zero-extended to `WIDTH+1`.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse; `out` and `borrow` are valid from this cycle onward.
- `out` output `WIDTH+1`: difference, modulo 2^(`WIDTH+1`).
- `borrow` output 1: final borrow. High iff `in0 < in1`.

## Operation
- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE → RUN** when `start` = 1. On that edge:
  - load operand shift registers `a` ← `in0` and `b` ← {0, `in1`};
  - clear the internal borrow `bin`;
  - set bit counter `cnt` ← 0.
- **RUN, each cycle:**
  - `d = a[0] ^ b[0] ^ bin`
  - `bout = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & bin)`
  - shift `d` into the MSB of the result shift register `r` (LSB-first accumulation);
  - shift `a` and `b` right by one;
  - `bin` ← `bout`;
  - `cnt` ← `cnt` + 1.
- **RUN → DONE** on the edge that processes bit `WIDTH` (`cnt` = `WIDTH`). On that edge, `out` ← the completed `r` and `borrow` ← `bout`.
- **DONE → IDLE** unconditionally on the next edge. `done` = 1 exactly while in DONE.
- `out` and `borrow` change only on RUN→DONE. They hold the last result through IDLE and the whole of the next RUN, so partial results are never visible.
- `start` is ignored in RUN and DONE. Operand inputs are don't-care outside the accept edge.
- **Width/arithmetic:** exact 10-bit two's-complement wrap. A negative result appears as 2^10 + (`in0` − `in1`) with `borrow` = 1.
- **Reset (any state, any time):** state → IDLE; `out`, `borrow`, `busy`, `done`, `a`, `b`, `r`, `bin`, `cnt` all → 0. An interrupted operation is discarded with no `done` pulse.

## Timing
- E0 = edge on which `start` is sampled high in IDLE. Bit i is computed on edge E(i+1), i = 0..`WIDTH`.
- `busy` rises after E0.
- DONE is entered at E(`WIDTH`+1) = E10. `done` is high for the one cycle after E10, and `out`/`borrow` are valid from that cycle.
- The FSM returns to IDLE at E11. The earliest next accept is E12, so the sustained throughput is one operation per 12 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deasserting near a clock edge must not be relied on. Use the project's standard reset release.

## Structure
- **Shared package:**
  - `WIDTH` default;
  - state encoding localparams `S_IDLE` = 2'd0, `S_RUN` = 2'd1, `S_DONE` = 2'd2;
  - counter width `$clog2(WIDTH+2)`.
- **Sub-module `full_subtractor`:** ports (`bout`, `diff`, `a`, `b`, `bin`), purely combinational, one instance. It is the single-bit counterpart of `full_adder` and is reusable for a future ripple subtractor.
- **Top level:** FSM, counter, three shift registers, output registers.

## Test plan
- **Basic subtract:** `in0` = 300, `in1` = 45, `start` for one cycle → `done` pulses exactly 10 edges after the accept, `out` = 255, `borrow` = 0, `busy` high for 11 cycles.
- **Underflow:** `in0` = 0, `in1` = 1 → `out` = 1023 (10'h3FF), `borrow` = 1.
- **Full range:**
  - `in0` = 1022, `in1` = 511 → `out` = 511, `borrow` = 0;
  - `in0` = 511, `in1` = 511 → `out` = 0, `borrow` = 0.
- **Ignored start:** start 600−100, then pulse `start` with 5−9 at cycles 3 and 10 (DONE) → single `done`, `out` = 500. The second request is never executed, and `out` holds 500 unchanged through later idle cycles.
- **Mid-operation reset:** assert `reset` 5 cycles into a RUN → `out`, `borrow`, `busy`, `done` = 0 immediately and no `done` pulse follows. A new `start` (100−1) after release → `out` = 99 after 10 cycles.
- **Held start:** hold `start` high continuously with `in0` = 7, `in1` = 3 → `done` pulses every 12 cycles, `out` = 4 each time.
